// File: rtl/seq_mult_pkg.sv
// ============================================================================
// Module   : seq_mult_pkg
// Brief    : Shared types and helpers for the iterative shift-and-add multiplier
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_mult_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

    // Widest operand abs_mag can handle; callers extend into this width.
    localparam int c_max_width = 64;

    // Magnitude of v when sgn is set and v is negative, otherwise v unchanged.
    // Callers sign-extend narrower operands so the most negative value maps to
    // its positive magnitude without wrapping.
    function automatic logic [c_max_width-1:0] abs_mag(
        input logic [c_max_width-1:0] v,
        input logic                   sgn
    );
        return (sgn && v[c_max_width-1]) ? (~v + c_max_width'(1)) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_multiplier.sv
// ============================================================================
// Module   : seq_multiplier
// Brief    : Iterative signed/unsigned shift-and-add multiplier, WIDTH+1 cycles
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = 4     // 2 .. c_max_width/2
) (
    input  logic                 fast_clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int c_cnt_w = $clog2(WIDTH);
    localparam int c_pw    = 2 * WIDTH;
    localparam int c_ext_w = c_max_width - WIDTH;

    mult_state_t          r_state;
    mult_state_t          w_state_next;
    logic                 r_busy;
    logic                 r_done;
    logic [c_pw-1:0]      r_product;

    logic [c_pw-1:0]      r_acc;
    logic [c_pw-1:0]      r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_accept;
    logic                 w_last;
    logic [c_max_width-1:0] w_a_ext;
    logic [c_max_width-1:0] w_b_ext;
    logic [c_max_width-1:0] w_a_abs;
    logic [c_max_width-1:0] w_b_abs;
    logic [c_pw-1:0]      w_acc_next;
    logic                 w_unused;

    assign w_accept = start && (r_state == IDLE || r_state == DONE);
    assign w_last   = (r_state == RUN) && (r_cnt == '0);

    // Sign-extend only in signed mode so abs_mag sees the true operand value.
    assign w_a_ext  = {{c_ext_w{mode_signed & a[WIDTH-1]}}, a};
    assign w_b_ext  = {{c_ext_w{mode_signed & b[WIDTH-1]}}, b};
    assign w_a_abs  = abs_mag(w_a_ext, mode_signed);
    assign w_b_abs  = abs_mag(w_b_ext, mode_signed);
    assign w_unused = ^{w_a_abs[c_max_width-1:WIDTH], w_b_abs[c_max_width-1:WIDTH]};

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (r_cnt == '0) w_state_next = DONE;
            DONE:    w_state_next = start ? RUN : IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == RUN);
            r_done  <= (w_state_next == DONE);
        end
    end

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_acc     <= '0;
            r_mcand   <= {{WIDTH{1'b0}}, w_a_abs[WIDTH-1:0]};
            r_mplier  <= w_b_abs[WIDTH-1:0];
            r_neg     <= mode_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_cnt     <= c_cnt_w'(WIDTH - 1);
        end else if (r_state == RUN) begin
            r_acc     <= w_acc_next;
            r_mcand   <= r_mcand << 1;
            r_mplier  <= r_mplier >> 1;
            r_cnt     <= r_cnt - c_cnt_w'(1);
            // Final partial product is folded in on the same edge as the sign fix-up.
            if (w_last) begin
                r_product <= r_neg ? (-w_acc_next) : w_acc_next;
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

`default_nettype wire

// File: tb/tb_seq_multiplier.sv
// ============================================================================
// Module   : tb_seq_multiplier
// Brief    : Scoreboard bench for seq_multiplier at WIDTH=4
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_multiplier;

    localparam int c_w = 4;

    logic             fast_clk;
    logic             rst;
    logic             start;
    logic             mode_signed;
    logic [c_w-1:0]   a;
    logic [c_w-1:0]   b;
    logic             busy;
    logic             done;
    logic [2*c_w-1:0] product;

    int               n_vec;
    int               n_err;
    logic [2*c_w-1:0] sb[$];

    seq_multiplier #(.WIDTH(c_w)) dut (
        .fast_clk    (fast_clk),
        .rst         (rst),
        .start       (start),
        .mode_signed (mode_signed),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    function automatic logic [2*c_w-1:0] model(input logic [c_w-1:0] x, input logic [c_w-1:0] y,
                                               input logic s);
        int xi, yi, p;
        xi = s ? int'($signed(x)) : int'(x);
        yi = s ? int'($signed(y)) : int'(y);
        p  = xi * yi;
        return p[2*c_w-1:0];
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge fast_clk);
        @(negedge fast_clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge fast_clk);
            n_vec++;
            if ({busy, done, product} !== 10'b0) begin
                n_err++;
                $display("FAIL reset_idle cyc=%0d got busy=%b done=%b product=%h want 0/0/00",
                         i, busy, done, product);
            end
        end
    endtask

    task automatic run_one(input logic [c_w-1:0] x, input logic [c_w-1:0] y, input logic s,
                           input string nm);
        int lat;
        logic [2*c_w-1:0] exp;
        lat = 0;
        @(posedge fast_clk); #1;
        a = x; b = y; mode_signed = s; start = 1'b1;
        sb.push_back(model(x, y, s));
        @(posedge fast_clk); #1;
        start = 1'b0; a = ~x; b = ~y; mode_signed = ~s;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge fast_clk);
            if (done) lat = n;
        end
        n_vec++;
        if (lat != c_w + 1) begin
            n_err++;
            $display("FAIL %s_latency got %0d want %0d", nm, lat, c_w + 1);
        end
        if (lat != 0 && sb.size() > 0) begin
            exp = sb.pop_front();
            n_vec++;
            if (product !== exp) begin
                n_err++;
                $display("FAIL %s_product got %h want %h", nm, product, exp);
            end
        end
        sb.delete();
    endtask

    task automatic test_unsigned_full();
        logic [2*c_w-1:0] exp;
        @(posedge fast_clk); #1;
        a = 4'd15; b = 4'd15; mode_signed = 1'b0; start = 1'b1;
        sb.push_back(model(4'd15, 4'd15, 1'b0));
        @(posedge fast_clk); #1;
        start = 1'b0; a = 4'd1; b = 4'd2;
        for (int n = 1; n <= 5; n++) begin
            @(negedge fast_clk);
            n_vec++;
            if (busy !== (n <= c_w) || done !== (n == c_w + 1)) begin
                n_err++;
                $display("FAIL uns_handshake cyc=%0d got busy=%b done=%b want %b/%b",
                         n, busy, done, (n <= c_w), (n == c_w + 1));
            end
        end
        exp = sb.pop_front();
        n_vec++;
        if (product !== exp || exp !== 8'hE1) begin
            n_err++;
            $display("FAIL uns_15x15 got %h want %h", product, exp);
        end
        for (int n = 0; n < 3; n++) begin
            @(negedge fast_clk);
            n_vec++;
            if (product !== exp || done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL uns_hold cyc=%0d got product=%h done=%b busy=%b want %h/0/0",
                         n, product, done, busy, exp);
            end
        end
    endtask

    task automatic test_signed();
        run_one(4'hD, 4'h5, 1'b1, "sgn_m3x5");
        run_one(4'h8, 4'h8, 1'b1, "sgn_m8xm8");
        run_one(4'h0, 4'h8, 1'b1, "sgn_0xm8");
        run_one(4'h7, 4'h9, 1'b1, "sgn_7xm7");
        run_one(4'h8, 4'h7, 1'b0, "uns_8x7");
    endtask

    task automatic test_back_to_back();
        logic [2*c_w-1:0] exp;
        int ndone;
        ndone = 0;
        @(posedge fast_clk); #1;
        a = 4'd2; b = 4'd3; mode_signed = 1'b0; start = 1'b1;
        sb.push_back(model(4'd2, 4'd3, 1'b0));
        @(posedge fast_clk); #1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge fast_clk);
            if (n == 2) begin a = 4'hF; b = 4'hF; end
            if (n == 6) begin
                n_vec++;
                if (busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL b2b_no_gap got busy=%b want 1", busy);
                end
            end
            n_vec++;
            if (done !== (n == 5 || n == 10)) begin
                n_err++;
                $display("FAIL b2b_done cyc=%0d got %b want %b", n, done, (n == 5 || n == 10));
            end
            if (done && sb.size() > 0) begin
                exp = sb.pop_front();
                ndone++;
                n_vec++;
                if (product !== exp) begin
                    n_err++;
                    $display("FAIL b2b_product%0d got %h want %h", ndone, product, exp);
                end
            end
            if (n == 5) begin
                a = 4'd7; b = 4'd7;
                sb.push_back(model(4'd7, 4'd7, 1'b0));
                @(posedge fast_clk); #1;
                start = 1'b0;
            end
        end
        n_vec++;
        if (ndone != 2) begin
            n_err++;
            $display("FAIL b2b_count got %0d want 2", ndone);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_run();
        @(posedge fast_clk); #1;
        a = 4'd9; b = 4'd9; mode_signed = 1'b0; start = 1'b1;
        @(posedge fast_clk); #1;
        start = 1'b0;
        repeat (3) @(negedge fast_clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, product} !== 10'b0) begin
            n_err++;
            $display("FAIL rst_async got busy=%b done=%b product=%h want 0/0/00", busy, done, product);
        end
        @(posedge fast_clk);
        @(negedge fast_clk);
        rst = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge fast_clk);
            n_vec++;
            if (done !== 1'b0 || busy !== 1'b0 || product !== 8'h00) begin
                n_err++;
                $display("FAIL rst_abandon cyc=%0d got done=%b busy=%b product=%h want 0/0/00",
                         n, done, busy, product);
            end
        end
        run_one(4'd9, 4'd9, 1'b0, "rst_restart");
    endtask

    task automatic test_exhaustive();
        logic [2*c_w-1:0] exp;
        int idx, got, since, guard;
        logic [c_w-1:0] x, y;
        idx = 0; got = 0; since = 0; guard = 0;
        @(posedge fast_clk); #1;
        {mode_signed, x, y} = 9'(idx);
        a = x; b = y; start = 1'b1;
        sb.push_back(model(x, y, mode_signed));
        @(posedge fast_clk); #1;
        while (got < 512 && guard < 512 * 6 + 20) begin
            @(negedge fast_clk);
            guard++;
            since++;
            if (done) begin
                exp = sb.pop_front();
                n_vec++;
                if (product !== exp || since != c_w + 1) begin
                    n_err++;
                    $display("FAIL exh idx=%0d got product=%h spacing=%0d want %h spacing=%0d",
                             got, product, since, exp, c_w + 1);
                end
                got++;
                since = 0;
                if (idx < 511) begin
                    idx++;
                    {mode_signed, x, y} = 9'(idx);
                    a = x; b = y;
                    sb.push_back(model(x, y, mode_signed));
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        n_vec++;
        if (got != 512 || sb.size() != 0) begin
            n_err++;
            $display("FAIL exh_complete got %0d products want 512", got);
        end
        sb.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_unsigned_full();
        test_signed();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive();
        repeat (3) @(posedge fast_clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
